operand_sequencer: RTL and testbench
====================================

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of idle cycles allowed between nibbles before a partial collection is abandoned; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 nib_in  input  4  nibble from switches.
REQ-005 nib_valid  input  1  nib_in is valid this cycle.
REQ-006 clear  input  1  synchronous abort of the current collection.
REQ-007 out_ready  input  1  ALU accepts the operand pair.
REQ-008 nib_ready  output  1  sequencer accepts a nibble this cycle.
REQ-009 buf_in0  output  4  low nibble to the byte buffer, registered.
REQ-010 buf_in1  output  4  high nibble to the byte buffer, registered.
REQ-011 op_a  output  8  operand A, {high,low}.
REQ-012 op_b  output  8  operand B, {high,low}.
REQ-013 op_valid  output  1  op_a/op_b complete and held.
REQ-014 nib_count  output  3  nibbles accepted in the current collection, 0..4.
REQ-015 timeout  output  1  one-cycle pulse when a partial collection is abandoned.

Function
REQ-016 FSM states: A_LO, A_HI, B_LO, B_HI, PRESENT; the reset state is A_LO.
REQ-017 nib_ready SHALL be 1 in A_LO..B_HI and 0 in PRESENT; a nibble is accepted only when nib_valid & nib_ready.
REQ-018 Accept in A_LO -> op_a[3:0]=nib_in and buf_in0=nib_in; go to A_HI.
REQ-019 Accept in A_HI -> op_a[7:4]=nib_in and buf_in1=nib_in; go to B_LO.
REQ-020 Accept in B_LO -> op_b[3:0]=nib_in and buf_in0=nib_in; go to B_HI.
REQ-021 Accept in B_HI -> op_b[7:4]=nib_in and buf_in1=nib_in; go to PRESENT.
REQ-022 Each accept SHALL increment nib_count in the same edge; nib_count=4 in PRESENT.
REQ-023 op_valid SHALL be 1 exactly while in PRESENT, asserted the cycle after the fourth accept (latency 1).
REQ-024 In PRESENT, op_a/op_b SHALL be held stable and nib_valid ignored.
REQ-025 In PRESENT with out_ready=1: transfer occurs; next state A_LO; nib_count=0; op_a/op_b retain their values until overwritten.
REQ-026 In PRESENT with out_ready=0: the state holds indefinitely with no timeout.
REQ-027 An idle counter SHALL clear on every accept and on entry to A_LO; it SHALL increment each cycle in A_HI, B_LO or B_HI without an accept.
REQ-028 When the idle counter reaches TIMEOUT in A_HI..B_HI: next state A_LO, nib_count=0, timeout pulses 1 for one cycle.
REQ-029 The idle counter SHALL not count in A_LO or PRESENT.
REQ-030 clear=1: next state A_LO, nib_count=0, idle counter=0, op_valid=0; op_a/op_b/buf_in* are unchanged.
REQ-031 clear SHALL have priority over nib_valid, out_ready and timeout in the same cycle; timeout does not pulse on clear.
REQ-032 Accept and timeout threshold in the same cycle: the accept wins and the counter clears.
REQ-033 All arithmetic is unsigned; no wrap of nib_count beyond 4.

Reset
REQ-034 While rst=1, asynchronously: state=A_LO, op_a=op_b=0, buf_in0=buf_in1=0, op_valid=0, nib_count=0, timeout=0, idle counter=0, nib_ready=1.
REQ-035 rst asserted mid-collection or during PRESENT SHALL discard all data; the first edge after deassertion behaves as A_LO.

Verification
REQ-036 After reset, feed nibbles 3,A,5,C one per cycle, out_ready=0 -> op_a=8'hA3, op_b=8'hC5, op_valid=1 one cycle after the 4th accept, and it holds.
REQ-037 With op_valid=1, raise out_ready for one cycle -> next cycle state A_LO, op_valid=0, nib_count=0, nib_ready=1.
REQ-038 TIMEOUT=4: accept one nibble then idle 4 cycles -> timeout pulses once, nib_count=0; the next nibble lands in op_a[3:0].
REQ-039 Assert clear together with nib_valid in B_LO -> nibble discarded, state A_LO, no timeout pulse.
REQ-040 Pulse rst asynchronously (between edges) during PRESENT -> all outputs zero immediately, nib_ready=1.
REQ-041 Drive nib_valid=1 continuously in PRESENT -> op_a/op_b unchanged and nib_count stays 4.

Source files
------------

// File: rtl/operand_sequencer_if.sv
// Handshake bundle between the switch front-end, the operand sequencer and the ALU.
// The master side drives nibbles and acknowledgements; the slave side is the sequencer.
interface operand_sequencer_if;
  logic [3:0] nib_in;
  logic       nib_valid;
  logic       clear;
  logic       out_ready;
  logic       nib_ready;
  logic [3:0] buf_in0;
  logic [3:0] buf_in1;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_valid;
  logic [2:0] nib_count;
  logic       timeout;

  modport master (
    output nib_in, nib_valid, clear, out_ready,
    input  nib_ready, buf_in0, buf_in1, op_a, op_b, op_valid, nib_count, timeout
  );

  modport slave (
    input  nib_in, nib_valid, clear, out_ready,
    output nib_ready, buf_in0, buf_in1, op_a, op_b, op_valid, nib_count, timeout
  );
endinterface

// File: rtl/operand_sequencer.sv
// Collects four switch nibbles into two byte operands and presents them to the ALU.
// A partial collection is abandoned after TIMEOUT idle cycles; clear aborts at any time.
module operand_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  operand_sequencer_if.slave bus
);

  typedef enum logic [2:0] {A_LO, A_HI, B_LO, B_HI, PRESENT} state_t;

  // Counter reaching TIMEOUT on this edge means it currently holds TIMEOUT-1.
  localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] idle_cnt;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [3:0] buf_in0;
  logic [3:0] buf_in1;
  logic [2:0] nib_count;
  logic       op_valid;
  logic       nib_ready;
  logic       timeout;
  logic       accept;

  assign accept = bus.nib_valid && nib_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= A_LO;
      idle_cnt  <= '0;
      op_a      <= '0;
      op_b      <= '0;
      buf_in0   <= '0;
      buf_in1   <= '0;
      nib_count <= '0;
      op_valid  <= 1'b0;
      nib_ready <= 1'b1;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (bus.clear) begin
        state     <= A_LO;
        idle_cnt  <= '0;
        nib_count <= '0;
        op_valid  <= 1'b0;
        nib_ready <= 1'b1;
      end else begin
        case (state)
          A_LO: begin
            if (accept) begin
              op_a[3:0] <= bus.nib_in;
              buf_in0   <= bus.nib_in;
              nib_count <= 3'd1;
              idle_cnt  <= '0;
              state     <= A_HI;
            end
          end
          A_HI, B_LO, B_HI: begin
            if (accept) begin
              nib_count <= nib_count + 3'd1;
              idle_cnt  <= '0;
              case (state)
                A_HI: begin
                  op_a[7:4] <= bus.nib_in;
                  buf_in1   <= bus.nib_in;
                  state     <= B_LO;
                end
                B_LO: begin
                  op_b[3:0] <= bus.nib_in;
                  buf_in0   <= bus.nib_in;
                  state     <= B_HI;
                end
                default: begin
                  op_b[7:4] <= bus.nib_in;
                  buf_in1   <= bus.nib_in;
                  op_valid  <= 1'b1;
                  nib_ready <= 1'b0;
                  state     <= PRESENT;
                end
              endcase
            end else if (idle_cnt == IDLE_LIMIT) begin
              state     <= A_LO;
              idle_cnt  <= '0;
              nib_count <= '0;
              timeout   <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
            end
          end
          PRESENT: begin
            if (bus.out_ready) begin
              state     <= A_LO;
              idle_cnt  <= '0;
              nib_count <= '0;
              op_valid  <= 1'b0;
              nib_ready <= 1'b1;
            end
          end
          default: begin
            state     <= A_LO;
            idle_cnt  <= '0;
            nib_count <= '0;
            op_valid  <= 1'b0;
            nib_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.op_a      = op_a;
  assign bus.op_b      = op_b;
  assign bus.buf_in0   = buf_in0;
  assign bus.buf_in1   = buf_in1;
  assign bus.nib_count = nib_count;
  assign bus.op_valid  = op_valid;
  assign bus.nib_ready = nib_ready;
  assign bus.timeout   = timeout;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with TIMEOUT=4 and hand-computed expectations.
module tb_operand_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  operand_sequencer_if bus();

  operand_sequencer #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the rising edge.
  task automatic applyStimulus(input logic [3:0] nib, input logic vld, input logic clr, input logic rdy);
    bus.nib_in    = nib;
    bus.nib_valid = vld;
    bus.clear     = clr;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.nib_in    = 4'h0;
    bus.nib_valid = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_op_a", 32'(bus.op_a), 32'h00);
    checkOutput("rst_op_b", 32'(bus.op_b), 32'h00);
    checkOutput("rst_buf0", 32'(bus.buf_in0), 32'h0);
    checkOutput("rst_buf1", 32'(bus.buf_in1), 32'h0);
    checkOutput("rst_valid", 32'(bus.op_valid), 32'h0);
    checkOutput("rst_count", 32'(bus.nib_count), 32'h0);
    checkOutput("rst_tmo", 32'(bus.timeout), 32'h0);
    checkOutput("rst_ready", 32'(bus.nib_ready), 32'h1);
    rst = 1'b0;

    applyStimulus(4'h3, 1'b1, 1'b0, 1'b0);
    checkOutput("n1_op_a", 32'(bus.op_a), 32'h03);
    checkOutput("n1_buf0", 32'(bus.buf_in0), 32'h3);
    checkOutput("n1_count", 32'(bus.nib_count), 32'h1);
    applyStimulus(4'hA, 1'b1, 1'b0, 1'b0);
    checkOutput("n2_op_a", 32'(bus.op_a), 32'hA3);
    checkOutput("n2_buf1", 32'(bus.buf_in1), 32'hA);
    checkOutput("n2_count", 32'(bus.nib_count), 32'h2);
    applyStimulus(4'h5, 1'b1, 1'b0, 1'b0);
    checkOutput("n3_op_b", 32'(bus.op_b), 32'h05);
    checkOutput("n3_buf0", 32'(bus.buf_in0), 32'h5);
    checkOutput("n3_valid", 32'(bus.op_valid), 32'h0);
    applyStimulus(4'hC, 1'b1, 1'b0, 1'b0);
    checkOutput("n4_op_a", 32'(bus.op_a), 32'hA3);
    checkOutput("n4_op_b", 32'(bus.op_b), 32'hC5);
    checkOutput("n4_buf1", 32'(bus.buf_in1), 32'hC);
    checkOutput("n4_count", 32'(bus.nib_count), 32'h4);
    checkOutput("n4_valid", 32'(bus.op_valid), 32'h1);
    checkOutput("n4_ready", 32'(bus.nib_ready), 32'h0);

    // PRESENT must hold with no timeout and ignore further nibbles.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'hF, (i >= 3), 1'b0, 1'b0);
      checkOutput("hold_valid", 32'(bus.op_valid), 32'h1);
      checkOutput("hold_tmo", 32'(bus.timeout), 32'h0);
      checkOutput("hold_count", 32'(bus.nib_count), 32'h4);
      checkOutput("hold_ops", {16'h0, bus.op_a, bus.op_b}, 32'hA3C5);
    end

    applyStimulus(4'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("xfer_valid", 32'(bus.op_valid), 32'h0);
    checkOutput("xfer_count", 32'(bus.nib_count), 32'h0);
    checkOutput("xfer_ready", 32'(bus.nib_ready), 32'h1);
    checkOutput("xfer_op_a", 32'(bus.op_a), 32'hA3);

    applyStimulus(4'h7, 1'b1, 1'b0, 1'b0);
    checkOutput("t_op_a", 32'(bus.op_a), 32'hA7);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("t_early_tmo", 32'(bus.timeout), 32'h0);
      checkOutput("t_early_cnt", 32'(bus.nib_count), 32'h1);
    end
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("t_fire_tmo", 32'(bus.timeout), 32'h1);
    checkOutput("t_fire_cnt", 32'(bus.nib_count), 32'h0);
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("t_pulse_end", 32'(bus.timeout), 32'h0);
    applyStimulus(4'h9, 1'b1, 1'b0, 1'b0);
    checkOutput("t_relo_op_a", 32'(bus.op_a), 32'hA9);
    checkOutput("t_relo_cnt", 32'(bus.nib_count), 32'h1);

    // Accept on the cycle the idle counter would hit the limit.
    for (int i = 0; i < 3; i++) applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h2, 1'b1, 1'b0, 1'b0);
    checkOutput("race_tmo", 32'(bus.timeout), 32'h0);
    checkOutput("race_cnt", 32'(bus.nib_count), 32'h2);
    checkOutput("race_op_a", 32'(bus.op_a), 32'h29);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("race_after_tmo", 32'(bus.timeout), 32'h0);
    end

    applyStimulus(4'hE, 1'b1, 1'b1, 1'b0);
    checkOutput("clr_cnt", 32'(bus.nib_count), 32'h0);
    checkOutput("clr_tmo", 32'(bus.timeout), 32'h0);
    checkOutput("clr_op_b", 32'(bus.op_b), 32'hC5);
    checkOutput("clr_buf0", 32'(bus.buf_in0), 32'h9);
    checkOutput("clr_ready", 32'(bus.nib_ready), 32'h1);
    applyStimulus(4'h1, 1'b1, 1'b0, 1'b0);
    checkOutput("clr_next_op_a", 32'(bus.op_a), 32'h21);
    checkOutput("clr_next_cnt", 32'(bus.nib_count), 32'h1);

    applyStimulus(4'h4, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'h6, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'h8, 1'b1, 1'b0, 1'b0);
    checkOutput("p2_ops", {16'h0, bus.op_a, bus.op_b}, 32'h4186);
    checkOutput("p2_valid", 32'(bus.op_valid), 32'h1);

    // Asynchronous reset pulse between clock edges.
    bus.nib_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_ops", {16'h0, bus.op_a, bus.op_b}, 32'h0000);
    checkOutput("arst_bufs", {24'h0, bus.buf_in1, bus.buf_in0}, 32'h00);
    checkOutput("arst_valid", 32'(bus.op_valid), 32'h0);
    checkOutput("arst_cnt", 32'(bus.nib_count), 32'h0);
    checkOutput("arst_ready", 32'(bus.nib_ready), 32'h1);
    rst = 1'b0;
    applyStimulus(4'h5, 1'b1, 1'b0, 1'b0);
    checkOutput("arst_next_op_a", 32'(bus.op_a), 32'h05);
    checkOutput("arst_next_cnt", 32'(bus.nib_count), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
